// File: rtl/warp_lsu_pkg.sv
// Shared types and defaults for the warp load-store unit.
// Scheduler/LSU phases, data/address widths and op encoding.
package warp_lsu_pkg;

    localparam int DATA_W                   = 8;
    localparam int ADDR_W                   = 8;
    localparam int DEFAULT_THREADS_PER_WARP = 16;
    localparam int DEFAULT_NUM_CHANNELS     = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] data_memory_address_t;

    typedef enum logic [2:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_DECODE,
        WARP_REQUEST,
        WARP_WAIT,
        WARP_EXECUTE,
        WARP_UPDATE,
        WARP_DONE
    } warp_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQUESTING,
        LSU_WAITING,
        LSU_DONE
    } lsu_state_t;

    typedef enum logic {
        LSU_OP_READ,
        LSU_OP_WRITE
    } lsu_op_t;

    typedef enum logic {
        CH_IDLE,
        CH_BUSY
    } ch_state_t;

    function automatic int lane_w(int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/warp_lsu_channel.sv
// One memory channel: picks the lowest pending lane of its subset
// (lanes with index % NUM_CHANNELS == CH_IDX) and runs valid/ready.
module warp_lsu_channel
    import warp_lsu_pkg::*;
#(
    parameter int THREADS_PER_WARP = DEFAULT_THREADS_PER_WARP,
    parameter int NUM_CHANNELS     = DEFAULT_NUM_CHANNELS,
    parameter int CH_IDX           = 0,
    parameter int LANE_W           = lane_w(THREADS_PER_WARP)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        active,
    input  logic [THREADS_PER_WARP-1:0] pending,
    input  data_memory_address_t        addr [THREADS_PER_WARP],
    input  data_t                       wdata [THREADS_PER_WARP],
    input  logic                        ready,
    output logic                        valid,
    output data_memory_address_t        addr_out,
    output data_t                       data_out,
    output logic                        done,
    output logic [LANE_W-1:0]           lane
);

    localparam int T = THREADS_PER_WARP;

    function automatic logic [T-1:0] sub_mask();
        logic [T-1:0] m;
        m = '0;
        for (int i = 0; i < T; i++) begin
            m[i] = ((i % NUM_CHANNELS) == CH_IDX);
        end
        return m;
    endfunction

    localparam logic [T-1:0] SUB_MASK = sub_mask();

    ch_state_t            state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    data_memory_address_t addr_q, addr_d;
    data_t                data_q, data_d;

    logic [T-1:0]         cand;
    logic                 found;
    logic [LANE_W-1:0]    pick;

    // Lowest-index pending lane belonging to this channel
    always_comb begin
        cand  = pending & SUB_MASK;
        found = |cand;
        pick  = '0;
        for (int i = T - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick = LANE_W'(i);
            end
        end
    end

    // Request FSM: raise valid for one lane, drop it on handshake
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done    = 1'b0;
        if (enable) begin
            unique case (state_q)
                CH_IDLE: begin
                    if (active && found) begin
                        state_d = CH_BUSY;
                        lane_d  = pick;
                        addr_d  = addr[pick];
                        data_d  = wdata[pick];
                    end
                end
                CH_BUSY: begin
                    if (ready) begin
                        state_d = CH_IDLE;
                        done    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CH_IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid    = (state_q == CH_BUSY);
    assign addr_out = addr_q;
    assign data_out = data_q;
    assign lane     = lane_q;

endmodule

// File: rtl/warp_lsu.sv
// Warp-wide load-store unit: latches per-lane operands and runs
// LDR/STR over NUM_CHANNELS memory channels until all lanes finish.
module warp_lsu
    import warp_lsu_pkg::*;
#(
    parameter int THREADS_PER_WARP = DEFAULT_THREADS_PER_WARP,
    parameter int NUM_CHANNELS     = DEFAULT_NUM_CHANNELS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  warp_state_t                 warp_state,
    input  logic                        decoded_mem_read_enable,
    input  logic                        decoded_mem_write_enable,
    input  logic [THREADS_PER_WARP-1:0] thread_mask,
    input  data_t                       rs1 [THREADS_PER_WARP],
    input  data_t                       rs2 [THREADS_PER_WARP],
    input  data_t                       imm,
    output logic [NUM_CHANNELS-1:0]     mem_read_valid,
    output data_memory_address_t        mem_read_address [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]     mem_read_ready,
    input  data_t                       mem_read_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]     mem_write_valid,
    output data_memory_address_t        mem_write_address [NUM_CHANNELS],
    output data_t                       mem_write_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]     mem_write_ready,
    output lsu_state_t                  lsu_state,
    output data_t                       lsu_out [THREADS_PER_WARP]
);

    localparam int T      = THREADS_PER_WARP;
    localparam int C      = NUM_CHANNELS;
    localparam int LANE_W = lane_w(T);

    lsu_state_t           state_q, state_d;
    lsu_op_t              op_q, op_d;
    logic [T-1:0]         pending_q, pending_d;
    data_memory_address_t addr_q [T];
    data_memory_address_t addr_d [T];
    data_t                wdata_q [T];
    data_t                wdata_d [T];
    data_t                out_q [T];
    data_t                out_d [T];

    logic                 ch_active;
    logic [C-1:0]         ch_ready;
    logic [C-1:0]         ch_valid;
    logic [C-1:0]         ch_done;
    logic [LANE_W-1:0]    ch_lane [C];
    data_memory_address_t ch_addr [C];
    data_t                ch_data [C];

    assign ch_active = (state_q == LSU_REQUESTING) ||
                       (state_q == LSU_WAITING);

    // Route the ready of the active direction and gate valids by op
    always_comb begin
        for (int c = 0; c < C; c++) begin
            ch_ready[c]          = (op_q == LSU_OP_READ) ?
                                   mem_read_ready[c] : mem_write_ready[c];
            mem_read_valid[c]    = ch_valid[c] && (op_q == LSU_OP_READ);
            mem_write_valid[c]   = ch_valid[c] && (op_q == LSU_OP_WRITE);
            mem_read_address[c]  = ch_addr[c];
            mem_write_address[c] = ch_addr[c];
            mem_write_data[c]    = ch_data[c];
        end
    end

    for (genvar g = 0; g < C; g++) begin : g_ch
        warp_lsu_channel #(
            .THREADS_PER_WARP (T),
            .NUM_CHANNELS     (C),
            .CH_IDX           (g),
            .LANE_W           (LANE_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .active   (ch_active),
            .pending  (pending_q),
            .addr     (addr_q),
            .wdata    (wdata_q),
            .ready    (ch_ready[g]),
            .valid    (ch_valid[g]),
            .addr_out (ch_addr[g]),
            .data_out (ch_data[g]),
            .done     (ch_done[g]),
            .lane     (ch_lane[g])
        );
    end

    // Warp FSM: latch operands, retire lanes, report completion
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pending_d = pending_q;
        for (int i = 0; i < T; i++) begin
            addr_d[i]  = addr_q[i];
            wdata_d[i] = wdata_q[i];
            out_d[i]   = out_q[i];
        end
        if (enable) begin
            for (int c = 0; c < C; c++) begin
                if (ch_done[c]) begin
                    pending_d[ch_lane[c]] = 1'b0;
                    if (op_q == LSU_OP_READ) begin
                        out_d[ch_lane[c]] = mem_read_data[c];
                    end
                end
            end
            unique case (state_q)
                LSU_IDLE: begin
                    if (warp_state == WARP_REQUEST &&
                        (decoded_mem_read_enable ^
                         decoded_mem_write_enable)) begin
                        op_d      = decoded_mem_read_enable ?
                                    LSU_OP_READ : LSU_OP_WRITE;
                        pending_d = thread_mask;
                        for (int i = 0; i < T; i++) begin
                            addr_d[i]  = data_memory_address_t'(rs1[i] + imm);
                            wdata_d[i] = rs2[i];
                        end
                        state_d = LSU_REQUESTING;
                    end
                end
                LSU_REQUESTING: begin
                    state_d = (pending_q == '0) ? LSU_DONE : LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (pending_d == '0) begin
                        state_d = LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (warp_state == WARP_UPDATE) begin
                        state_d = LSU_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Warp-level state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LSU_IDLE;
            op_q      <= LSU_OP_READ;
            pending_q <= '0;
            for (int i = 0; i < T; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                out_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pending_q <= pending_d;
            for (int i = 0; i < T; i++) begin
                addr_q[i]  <= addr_d[i];
                wdata_q[i] <= wdata_d[i];
                out_q[i]   <= out_d[i];
            end
        end
    end

    assign lsu_state = state_q;
    assign lsu_out   = out_q;

endmodule

// File: tb/tb_warp_lsu.sv
// Scoreboard bench for warp_lsu with 4 lanes over 2 channels.
// Memory answers data = address + 100 two cycles after valid.
module tb_warp_lsu;
    import warp_lsu_pkg::*;

    localparam int T = 4;
    localparam int C = 2;

    typedef struct {
        bit wr;
        int addr;
        int data;
    } txn_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    warp_state_t          warp_state;
    logic                 rd_en;
    logic                 wr_en;
    logic [T-1:0]         thread_mask;
    data_t                rs1 [T];
    data_t                rs2 [T];
    data_t                imm;
    logic [C-1:0]         mem_read_valid;
    data_memory_address_t mem_read_address [C];
    logic [C-1:0]         mem_read_ready;
    data_t                mem_read_data [C];
    logic [C-1:0]         mem_write_valid;
    data_memory_address_t mem_write_address [C];
    data_t                mem_write_data [C];
    logic [C-1:0]         mem_write_ready;
    lsu_state_t           lsu_state;
    data_t                lsu_out [T];

    int   checks   = 0;
    int   failures = 0;
    bit   hold_ready = 0;
    int   cnt [C];
    bit   prev_hs [C];
    int   exp_out [T];
    txn_t q0 [$];
    txn_t q1 [$];

    warp_lsu #(
        .THREADS_PER_WARP (T),
        .NUM_CHANNELS     (C)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .warp_state               (warp_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .thread_mask              (thread_mask),
        .rs1                      (rs1),
        .rs2                      (rs2),
        .imm                      (imm),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(int ch, bit wr, int addr, int data);
        txn_t t;
        t.wr   = wr;
        t.addr = addr;
        t.data = data;
        if (ch == 0) q0.push_back(t);
        else q1.push_back(t);
    endtask

    // Memory model: ready after two cycles of valid, or always
    always @(negedge clk) begin
        for (int c = 0; c < C; c++) begin
            if (!reset || !(mem_read_valid[c] || mem_write_valid[c]))
                cnt[c] = 0;
            else
                cnt[c] = cnt[c] + 1;
            mem_read_ready[c]  = hold_ready || cnt[c] >= 2;
            mem_write_ready[c] = hold_ready || cnt[c] >= 2;
            mem_read_data[c]   = data_t'(mem_read_address[c] + 8'd100);
        end
    end

    // Monitor: compare each handshake against the expected queue
    always begin
        @(negedge clk);
        #4;
        for (int c = 0; c < C; c++) begin
            bit   rv;
            bit   wv;
            int   qs;
            txn_t t;
            rv = mem_read_valid[c];
            wv = mem_write_valid[c];
            qs = (c == 0) ? q0.size() : q1.size();
            if (prev_hs[c]) chk("valid_gap", int'(rv | wv), 0);
            prev_hs[c] = 0;
            if ((rv || wv) && qs == 0) begin
                chk("unexpected_traffic", int'(rv | wv), 0);
            end else if (reset && enable &&
                         ((rv && mem_read_ready[c]) ||
                          (wv && mem_write_ready[c]))) begin
                if (c == 0) t = q0.pop_front();
                else t = q1.pop_front();
                chk("kind", int'(wv), int'(t.wr));
                if (wv) begin
                    chk("wr_addr", int'(mem_write_address[c]), t.addr);
                    chk("wr_data", int'(mem_write_data[c]), t.data);
                end else begin
                    chk("rd_addr", int'(mem_read_address[c]), t.addr);
                end
                prev_hs[c] = 1;
            end
        end
    end

    task automatic start(bit rd, bit wr, logic [T-1:0] m);
        warp_state  = WARP_REQUEST;
        rd_en       = rd;
        wr_en       = wr;
        thread_mask = m;
        @(negedge clk);
        warp_state  = WARP_WAIT;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        thread_mask = '0;
        for (int i = 0; i < T; i++) begin
            rs1[i] = 8'hEE;
            rs2[i] = 8'hDD;
        end
    endtask

    task automatic wait_state(lsu_state_t tgt, string name);
        int n;
        n = 0;
        while (lsu_state !== tgt && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(lsu_state), int'(tgt));
    endtask

    task automatic check_out(string name);
        for (int i = 0; i < T; i++) begin
            chk(name, int'(lsu_out[i]), exp_out[i]);
        end
    endtask

    task automatic release_warp();
        warp_state = WARP_UPDATE;
        @(negedge clk);
        chk("update_idle", int'(lsu_state), int'(LSU_IDLE));
        warp_state = WARP_WAIT;
        chk("queues_drained", q0.size() + q1.size(), 0);
    endtask

    task automatic set_rs1(int a, int b, int c, int d);
        rs1[0] = data_t'(a);
        rs1[1] = data_t'(b);
        rs1[2] = data_t'(c);
        rs1[3] = data_t'(d);
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b1;
        warp_state  = WARP_IDLE;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        thread_mask = '0;
        imm         = 8'd4;
        for (int i = 0; i < T; i++) begin
            rs1[i]     = '0;
            rs2[i]     = '0;
            exp_out[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk("reset_state", int'(lsu_state), int'(LSU_IDLE));
        chk("reset_rvalid", int'(mem_read_valid), 0);
        chk("reset_wvalid", int'(mem_write_valid), 0);
        check_out("reset_out");
        reset = 1'b1;
        @(negedge clk);

        // 1: full-mask load
        set_rs1(0, 10, 20, 30);
        push(0, 0, 4, 0);
        push(0, 0, 24, 0);
        push(1, 0, 14, 0);
        push(1, 0, 34, 0);
        exp_out = '{104, 114, 124, 134};
        start(1'b1, 1'b0, 4'b1111);
        wait_state(LSU_DONE, "t1_done");
        check_out("t1_out");
        release_warp();

        // 2: store on lanes 0 and 2 only
        set_rs1(40, 50, 60, 70);
        rs2 = '{8'd7, 8'd8, 8'd9, 8'd10};
        push(0, 1, 44, 7);
        push(0, 1, 64, 9);
        start(1'b0, 1'b1, 4'b0101);
        wait_state(LSU_DONE, "t2_done");
        check_out("t2_out_unchanged");
        release_warp();

        // 3: empty mask
        start(1'b1, 1'b0, 4'b0000);
        chk("t3_requesting", int'(lsu_state), int'(LSU_REQUESTING));
        @(negedge clk);
        chk("t3_done", int'(lsu_state), int'(LSU_DONE));
        release_warp();

        // 4: freeze with ready held high
        hold_ready = 1;
        set_rs1(1, 2, 3, 5);
        push(0, 0, 5, 0);
        push(0, 0, 7, 0);
        push(1, 0, 6, 0);
        push(1, 0, 9, 0);
        start(1'b1, 1'b0, 4'b1111);
        @(negedge clk);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t4_freeze_state", int'(lsu_state), int'(LSU_WAITING));
            chk("t4_freeze_valid", int'(mem_read_valid), 3);
            check_out("t4_freeze_out");
        end
        enable = 1'b1;
        exp_out = '{105, 106, 107, 109};
        wait_state(LSU_DONE, "t4_done");
        check_out("t4_out");
        hold_ready = 0;
        release_warp();

        // 5: asynchronous reset while waiting
        set_rs1(0, 10, 20, 30);
        push(0, 0, 4, 0);
        push(1, 0, 14, 0);
        start(1'b1, 1'b0, 4'b1111);
        @(negedge clk);
        chk("t5_waiting", int'(lsu_state), int'(LSU_WAITING));
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rvalid_drop", int'(mem_read_valid), 0);
        chk("t5_state", int'(lsu_state), int'(LSU_IDLE));
        exp_out = '{0, 0, 0, 0};
        check_out("t5_out");
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 6a: illegal decode with both enables
        set_rs1(0, 10, 20, 30);
        start(1'b1, 1'b1, 4'b1111);
        chk("t6_illegal_idle", int'(lsu_state), int'(LSU_IDLE));
        @(negedge clk);
        chk("t6_illegal_idle2", int'(lsu_state), int'(LSU_IDLE));

        // 6b: WARP_UPDATE ignored while waiting
        set_rs1(0, 10, 20, 30);
        push(0, 0, 4, 0);
        push(1, 0, 14, 0);
        exp_out = '{104, 114, 0, 0};
        start(1'b1, 1'b0, 4'b0011);
        @(negedge clk);
        warp_state = WARP_UPDATE;
        @(negedge clk);
        chk("t6_update_ignored", int'(lsu_state), int'(LSU_WAITING));
        warp_state = WARP_WAIT;
        wait_state(LSU_DONE, "t6_done");
        check_out("t6_out");
        release_warp();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
